// File: rtl/hs_mux_n_if.sv
// -----------------------------------------------------------------------------
// hs_mux_n_if
//   Bundle of the two-phase (toggle) bundled-data channels around hs_mux_n.
//   Every *_req / *_ack pair signals an event by toggling. A channel is pending
//   whenever its req and ack differ.
//
//   Parameters
//     N      number of input channels
//     W      data width per channel
//     SEL_W  width of a channel index (max(1, clog2(N)))
//
//   Signals (direction seen from the mux, i.e. the slave modport)
//     in_req   [N]      in   per-channel request toggle
//     in_data  [N*W]    in   channel c data at [c*W +: W]
//     in_ack   [N]      out  per-channel acknowledge toggle
//     sel_req           in   select-token request toggle
//     sel_data [SEL_W]  in   requested channel index
//     sel_ack           out  select-token acknowledge toggle
//     out_req           out  output request toggle
//     out_data [W]      out  output data
//     out_chan [SEL_W]  out  channel that sourced out_data
//     out_ack           in   output acknowledge toggle
//     busy              out  a token is being steered
//     err_sel           out  one-cycle pulse on an out-of-range select token
//
//   Modports
//     master  environment side (producers, select source, consumer)
//     slave   mux side
// -----------------------------------------------------------------------------
interface hs_mux_n_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = (N > 2) ? $clog2(N) : 1
);
  logic [N-1:0]     in_req;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ack;
  logic             sel_req;
  logic [SEL_W-1:0] sel_data;
  logic             sel_ack;
  logic             out_req;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_ack;
  logic             busy;
  logic             err_sel;

  modport master (
    output in_req, in_data, sel_req, sel_data, out_ack,
    input  in_ack, sel_ack, out_req, out_data, out_chan, busy, err_sel
  );

  modport slave (
    input  in_req, in_data, sel_req, sel_data, out_ack,
    output in_ack, sel_ack, out_req, out_data, out_chan, busy, err_sel
  );
endinterface

// File: rtl/hs_mux_n.sv
// -----------------------------------------------------------------------------
// hs_mux_n
//   Clocked N-way two-phase bundled-data multiplexer. Self-timed producers and
//   a self-timed consumer are bridged into the clk domain: every incoming
//   req/ack toggle passes through a SYNC_STAGES-deep synchroniser, and exactly
//   one token is in flight at a time.
//     MODE 0  a select token names the channel that is forwarded next.
//     MODE 1  round-robin merge of all pending channels (select port unused).
//
//   Ports
//     clk    in  clock
//     rst_n  in  asynchronous active-low reset
//     bus    hs_mux_n_if.slave, all handshake and data signals
//
//   Data and select index are sampled directly from the bus on the capture
//   edge. They are bundled data: the sender holds them stable from its req
//   toggle until the matching ack toggle, so the synchronised req (which lags
//   the raw req) guarantees they have long settled.
// -----------------------------------------------------------------------------
module hs_mux_n #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst_n,
  hs_mux_n_if.slave bus
);

  localparam int SEL_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t state, state_n;

  // Synchroniser chains: index 0 samples the raw input, index SYNC_STAGES-1
  // is the value the control logic is allowed to look at.
  logic [SYNC_STAGES-1:0][N-1:0] in_sync;
  logic [SYNC_STAGES-1:0]        sel_sync;
  logic [SYNC_STAGES-1:0]        oack_sync;

  // Registered handshake outputs and datapath.
  logic [N-1:0]     in_ack_q;
  logic             sel_ack_q;
  logic             out_req_q;
  logic [W-1:0]     out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic             err_q;
  logic [SEL_W-1:0] idx_q;     // channel currently being served
  logic [SEL_W-1:0] rr_q;      // round-robin starting point

  // Event decode. Only inequality matters, so both toggle directions are
  // treated alike.
  logic [N-1:0] pend;
  logic         spend;
  logic         done;

  assign pend  = in_sync[SYNC_STAGES-1] ^ in_ack_q;
  assign spend = sel_sync[SYNC_STAGES-1] ^ sel_ack_q;
  assign done  = (oack_sync[SYNC_STAGES-1] == out_req_q);

  // Round-robin arbiter: first pending channel at or after rr_q, wrapping.
  logic             rr_found;
  logic [SEL_W-1:0] rr_win;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && pend[(int'(rr_q) + k) % N]) begin
        rr_found = 1'b1;
        rr_win   = SEL_W'((int'(rr_q) + k) % N);
      end
    end
  end

  // Next-state and control decode.
  logic             capture;   // load out_data/out_chan, toggle out_req
  logic [SEL_W-1:0] cap_chan;  // channel sampled on a capture
  logic [SEL_W-1:0] idx_n;
  logic [SEL_W-1:0] rr_n;
  logic             ack_fire;  // toggle in_ack[idx_q]
  logic             sel_fire;  // toggle sel_ack
  logic             err_n;

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    cap_chan = idx_q;
    idx_n    = idx_q;
    rr_n     = rr_q;
    ack_fire = 1'b0;
    sel_fire = 1'b0;
    err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (MODE == 0) begin
          if (spend) begin
            if (int'(bus.sel_data) >= N) begin
              // Bad index: consume the select token and flag it; nothing
              // is forwarded and the input channels are left alone.
              sel_fire = 1'b1;
              err_n    = 1'b1;
            end else begin
              idx_n   = bus.sel_data;
              state_n = ARMED;
            end
          end
        end else if (rr_found) begin
          idx_n    = rr_win;
          cap_chan = rr_win;
          capture  = 1'b1;
          rr_n     = (int'(rr_win) == N - 1) ? '0 : rr_win + SEL_W'(1);
          state_n  = XFER;
        end
      end

      ARMED: begin
        // Only the selected channel may proceed; other pending channels
        // stay pending until their own select token arrives.
        if (pend[idx_q]) begin
          capture = 1'b1;
          state_n = XFER;
        end
      end

      XFER: begin
        if (done) begin
          ack_fire = 1'b1;
          sel_fire = (MODE == 0);
          state_n  = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop, independent of the
  // order of statements in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_sync    <= '0;
      sel_sync   <= '0;
      oack_sync  <= '0;
      in_ack_q   <= '0;
      sel_ack_q  <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      rr_q       <= '0;
    end else begin
      in_sync   <= {in_sync[SYNC_STAGES-2:0], bus.in_req};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], bus.sel_req};
      oack_sync <= {oack_sync[SYNC_STAGES-2:0], bus.out_ack};

      state <= state_n;
      idx_q <= idx_n;
      rr_q  <= rr_n;
      err_q <= err_n;

      if (capture) begin
        out_data_q <= bus.in_data[cap_chan*W +: W];
        out_chan_q <= cap_chan;
        out_req_q  <= ~out_req_q;
      end

      if (ack_fire) begin
        in_ack_q[idx_q] <= ~in_ack_q[idx_q];
      end

      if (sel_fire) begin
        sel_ack_q <= ~sel_ack_q;
      end
    end
  end

  assign bus.in_ack   = in_ack_q;
  assign bus.sel_ack  = sel_ack_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
  assign bus.out_chan = out_chan_q;
  assign bus.err_sel  = err_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_hs_mux_n.sv
// -----------------------------------------------------------------------------
// tb_hs_mux_n
//   Directed bench for hs_mux_n. Three instances share clk/rst_n:
//     u0 : MODE 0, N=4   select-steered mux
//     u1 : MODE 0, N=3   out-of-range select handling
//     u2 : MODE 1, N=4   round-robin merge
//   Expected output tokens are pushed to a scoreboard queue when the stimulus
//   that makes them deterministic is driven, and popped when out_req toggles.
// -----------------------------------------------------------------------------
module tb_hs_mux_n;

  localparam int W  = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hs_mux_n_if #(.N(4), .W(W)) if0 ();
  hs_mux_n_if #(.N(3), .W(W)) if3 ();
  hs_mux_n_if #(.N(4), .W(W)) if1 ();

  hs_mux_n #(.N(4), .W(W), .MODE(0), .SYNC_STAGES(SS)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  hs_mux_n #(.N(3), .W(W), .MODE(0), .SYNC_STAGES(SS)) u1 (.clk(clk), .rst_n(rst_n), .bus(if3));
  hs_mux_n #(.N(4), .W(W), .MODE(1), .SYNC_STAGES(SS)) u2 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic oreq_seen [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- unit accessors (u: 0 = u0, 1 = u1, 2 = u2) ----
  function automatic logic [3:0] in_ack_of(input int u);
    case (u)
      0:       return if0.in_ack;
      1:       return {1'b0, if3.in_ack};
      default: return if1.in_ack;
    endcase
  endfunction

  function automatic logic out_req_of(input int u);
    case (u)
      0:       return if0.out_req;
      1:       return if3.out_req;
      default: return if1.out_req;
    endcase
  endfunction

  function automatic logic [7:0] out_data_of(input int u);
    case (u)
      0:       return if0.out_data;
      1:       return if3.out_data;
      default: return if1.out_data;
    endcase
  endfunction

  function automatic logic [1:0] out_chan_of(input int u);
    case (u)
      0:       return if0.out_chan;
      1:       return if3.out_chan;
      default: return if1.out_chan;
    endcase
  endfunction

  function automatic logic sel_ack_of(input int u);
    case (u)
      0:       return if0.sel_ack;
      1:       return if3.sel_ack;
      default: return if1.sel_ack;
    endcase
  endfunction

  function automatic logic busy_of(input int u);
    case (u)
      0:       return if0.busy;
      1:       return if3.busy;
      default: return if1.busy;
    endcase
  endfunction

  function automatic logic err_sel_of(input int u);
    case (u)
      0:       return if0.err_sel;
      1:       return if3.err_sel;
      default: return if1.err_sel;
    endcase
  endfunction

  // ---- drivers (caller aligns them to the falling edge) ----
  task automatic drive_in(input int u, input int c, input logic [7:0] d);
    case (u)
      0: begin if0.in_data[c*W +: W] = d; if0.in_req[c] = !if0.in_req[c]; end
      1: begin if3.in_data[c*W +: W] = d; if3.in_req[c] = !if3.in_req[c]; end
      default: begin if1.in_data[c*W +: W] = d; if1.in_req[c] = !if1.in_req[c]; end
    endcase
  endtask

  task automatic drive_sel(input int u, input logic [1:0] idx);
    case (u)
      0:       begin if0.sel_data = idx; if0.sel_req = !if0.sel_req; end
      default: begin if3.sel_data = idx; if3.sel_req = !if3.sel_req; end
    endcase
  endtask

  task automatic drive_oack(input int u);
    case (u)
      0:       if0.out_ack = !if0.out_ack;
      1:       if3.out_ack = !if3.out_ack;
      default: if1.out_ack = !if1.out_ack;
    endcase
  endtask

  task automatic env_reset();
    if0.in_req = '0; if0.in_data = '0; if0.sel_req = 1'b0; if0.sel_data = '0; if0.out_ack = 1'b0;
    if3.in_req = '0; if3.in_data = '0; if3.sel_req = 1'b0; if3.sel_data = '0; if3.out_ack = 1'b0;
    if1.in_req = '0; if1.in_data = '0; if1.sel_req = 1'b0; if1.sel_data = '0; if1.out_ack = 1'b0;
    for (int i = 0; i < 3; i++) oreq_seen[i] = 1'b0;
    sb.delete();
  endtask

  // Wait (bounded) for the next out_req toggle, then compare against the
  // scoreboard head. lat = rising edges seen since the call.
  task automatic expect_out(input int u, input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (out_req_of(u) == oreq_seen[u] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_req"}, out_req_of(u), !oreq_seen[u]);
    oreq_seen[u] = out_req_of(u);
    if (sb.size() > 0) e = sb.pop_front();
    else               e = '1;
    check({tag, "_data"}, out_data_of(u), e.data);
    check({tag, "_chan"}, out_chan_of(u), e.chan);
  endtask

  // Toggle out_ack on a falling edge, then wait (bounded) for in_ack[chan]
  // and, if want_sel, sel_ack. Latencies are rising edges after the toggle.
  task automatic ack_and_wait(input int u, input int chan, input bit want_sel,
                              input string tag, output int ack_lat, output int sel_lat);
    logic [3:0] a0;
    logic       s0;
    int         n;
    @(negedge clk);
    a0 = in_ack_of(u);
    s0 = sel_ack_of(u);
    drive_oack(u);
    ack_lat = 0;
    sel_lat = 0;
    n       = 0;
    while ((ack_lat == 0 || (want_sel && sel_lat == 0)) && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ack_lat == 0 && in_ack_of(u) != a0) ack_lat = n;
      if (sel_lat == 0 && sel_ack_of(u) != s0) sel_lat = n;
    end
    check({tag, "_in_ack"}, in_ack_of(u), a0 ^ (4'b0001 << chan));
    if (want_sel) check({tag, "_sel_ack"}, sel_ack_of(u), !s0);
  endtask

  task automatic wait_busy(input int u, input string tag);
    int n;
    n = 0;
    while (!busy_of(u) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_armed"}, busy_of(u), 1'b1);
  endtask

  // Select token 2, then channel 2 carries A5; latencies are SS+1 edges.
  task automatic run_t1(input string tag);
    int lat, al, sl;
    @(negedge clk);
    drive_sel(0, 2'd2);
    wait_busy(0, tag);
    @(negedge clk);
    drive_in(0, 2, 8'hA5);
    sb.push_back('{chan: 2'd2, data: 8'hA5});
    expect_out(0, tag, lat);
    check({tag, "_out_lat"}, lat, SS + 1);
    ack_and_wait(0, 2, 1'b1, tag, al, sl);
    check({tag, "_ack_lat"}, al, SS + 1);
    check({tag, "_sel_same_edge"}, sl, al);
    check({tag, "_idle"}, busy_of(0), 1'b0);
  endtask

  initial begin
    int   lat, al, sl, errs;
    logic s0;
    logic [7:0] d;

    // ---- reset values ----
    rst_n = 1'b0;
    env_reset();
    repeat (3) @(negedge clk);
    check("rst_out_req",  out_req_of(0),  1'b0);
    check("rst_out_data", out_data_of(0), 8'h00);
    check("rst_out_chan", out_chan_of(0), 2'd0);
    check("rst_in_ack",   in_ack_of(0),   4'h0);
    check("rst_sel_ack",  sel_ack_of(0),  1'b0);
    check("rst_busy",     busy_of(0),     1'b0);
    check("rst_err_sel",  err_sel_of(0),  1'b0);
    check("rst_rr_out",   out_req_of(2),  1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- 1: basic select-steered transfer ----
    run_t1("t1");

    // ---- 2: unselected pending channel is left alone ----
    @(negedge clk);
    drive_in(0, 1, 8'h11);
    @(negedge clk);
    drive_sel(0, 2'd3);
    wait_busy(0, "t2");
    @(negedge clk);
    drive_in(0, 3, 8'h33);
    sb.push_back('{chan: 2'd3, data: 8'h33});
    expect_out(0, "t2a", lat);
    ack_and_wait(0, 3, 1'b1, "t2a", al, sl);
    repeat (10) @(negedge clk);
    check("t2_ch1_held_req", out_req_of(0), oreq_seen[0]);
    check("t2_ch1_held_ack", in_ack_of(0) & 4'b0010, 4'b0000);
    drive_sel(0, 2'd1);
    sb.push_back('{chan: 2'd1, data: 8'h11});
    expect_out(0, "t2b", lat);
    ack_and_wait(0, 1, 1'b1, "t2b", al, sl);

    // ---- 3: out-of-range select on N=3 ----
    @(negedge clk);
    s0 = sel_ack_of(1);
    drive_sel(1, 2'd3);
    errs = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (err_sel_of(1)) errs++;
    end
    check("t3_sel_ack", sel_ack_of(1), !s0);
    check("t3_err_pulses", errs, 1);
    check("t3_no_out", out_req_of(1), 1'b0);
    check("t3_idle", busy_of(1), 1'b0);

    // ---- 4: round-robin merge ----
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      drive_in(2, c, 8'(c));
      sb.push_back('{chan: 2'(c), data: 8'(c)});
    end
    for (int k = 0; k < 4; k++) begin
      expect_out(2, "t4a", lat);
      ack_and_wait(2, k, 1'b0, "t4a", al, sl);
    end
    @(negedge clk);
    drive_in(2, 3, 8'h13);
    drive_in(2, 1, 8'h11);
    sb.push_back('{chan: 2'd1, data: 8'h11});
    sb.push_back('{chan: 2'd3, data: 8'h13});
    expect_out(2, "t4b", lat);
    ack_and_wait(2, 1, 1'b0, "t4b", al, sl);
    expect_out(2, "t4c", lat);
    ack_and_wait(2, 3, 1'b0, "t4c", al, sl);

    // ---- 5: 20 back-to-back tokens, random consumer delay ----
    for (int t = 0; t < 20; t++) begin
      d = 8'($urandom);
      @(negedge clk);
      drive_in(2, 2, d);
      sb.push_back('{chan: 2'd2, data: d});
      expect_out(2, "t5", lat);
      repeat ($urandom_range(0, 50)) @(negedge clk);
      ack_and_wait(2, 2, 1'b0, "t5", al, sl);
    end
    repeat (10) @(negedge clk);
    check("t5_no_extra", out_req_of(2), oreq_seen[2]);
    check("t5_sb_drained", sb.size(), 0);

    // ---- 6: reset while in XFER ----
    @(negedge clk);
    drive_sel(0, 2'd0);
    wait_busy(0, "t6");
    @(negedge clk);
    drive_in(0, 0, 8'h5A);
    sb.push_back('{chan: 2'd0, data: 8'h5A});
    expect_out(0, "t6", lat);
    check("t6_in_xfer", busy_of(0), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_req",  out_req_of(0),  1'b0);
    check("t6_rst_out_data", out_data_of(0), 8'h00);
    check("t6_rst_out_chan", out_chan_of(0), 2'd0);
    check("t6_rst_in_ack",   in_ack_of(0),   4'h0);
    check("t6_rst_sel_ack",  sel_ack_of(0),  1'b0);
    check("t6_rst_busy",     busy_of(0),     1'b0);
    env_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_t1("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
